// File: rtl/gpio_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_port_pkg
// Description : Shared CPU definitions for the GPIO port: register offsets,
//               edge-mode encodings, PORTA base address and edge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_port_pkg;

    typedef enum logic [1:0] {
        PORT_REG_OUT  = 2'd0,
        PORT_REG_DIR  = 2'd1,
        PORT_REG_PIN  = 2'd2,
        PORT_REG_FLAG = 2'd3
    } port_reg_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_BOTH    = 2;

    localparam logic [15:0] PORTA_BASE = 16'h8000;

    // s2 is the newer synchronised sample, s3 the one before it.
    function automatic logic edge_hit(input int mode, input logic s2, input logic s3);
        logic w_rise;
        logic w_fall;
        w_rise = s2 & ~s3;
        w_fall = ~s2 & s3;
        if (mode == EDGE_FALLING) begin
            return w_fall;
        end else if (mode == EDGE_BOTH) begin
            return w_rise | w_fall;
        end
        return w_rise;
    endfunction

endpackage : gpio_port_pkg
`default_nettype wire

// File: rtl/gpio_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : gpio_edge_detect
// Description : One pad bit: 3-flop synchroniser, edge detector and sticky
//               write-1-to-clear event flag.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_edge_detect
    import gpio_port_pkg::*;
#(
    parameter int EDGE_MODE = EDGE_RISING
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    input  logic dir,
    input  logic clr,
    output logic sync,
    output logic flag
);

    // r_sync[0] = S1, r_sync[1] = S2, r_sync[2] = S3
    logic [2:0] r_sync;
    logic       r_flag;
    logic       w_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], pad};
        end
    end

    // Output bits never raise events; dir is the value before any same-cycle write.
    assign w_edge = ~dir & edge_hit(EDGE_MODE, r_sync[1], r_sync[2]);

    // A new edge beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag <= 1'b0;
        end else begin
            r_flag <= (r_flag & ~clr) | w_edge;
        end
    end

    assign sync = r_sync[1];
    assign flag = r_flag;

endmodule : gpio_edge_detect
`default_nettype wire

// File: rtl/tri_state_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tri_state_buffer
// Description : Per-bit tri-state driver; bit i drives i_data[i] when i_en[i].
// Revision    : 1.0 - initial release
// ============================================================================
module tri_state_buffer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_en,
    output wire  [WIDTH-1:0] o_pad
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_pad[i] = i_en[i] ? i_data[i] : 1'bz;
    end

endmodule : tri_state_buffer
`default_nettype wire

// File: rtl/gpio_port.sv
`default_nettype none
// ============================================================================
// Module      : gpio_port
// Description : Memory-mapped GPIO port with output latch, direction register,
//               synchronised pin readback and sticky edge flags driving irq.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_port
    import gpio_port_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_MODE  = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  CS,
    input  logic                  OE,
    input  logic                  WE,
    inout  wire  [DATA_WIDTH-1:0] gpio,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] w_pin;
    logic [DATA_WIDTH-1:0] w_flag;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_wr;
    logic                  w_rd;

    // A write strobe suppresses the read driver so the bus never contends.
    assign w_wr = CS & WE;
    assign w_rd = CS & OE & ~WE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
            r_dir <= '0;
        end else if (w_wr) begin
            case (port_reg_e'(address))
                PORT_REG_OUT: r_out <= data;
                PORT_REG_DIR: r_dir <= data;
                PORT_REG_PIN: r_out <= r_out ^ data;
                default:      ;
            endcase
        end
    end

    assign w_clr = (w_wr && (port_reg_e'(address) == PORT_REG_FLAG)) ? data : '0;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_edge
        gpio_edge_detect #(
            .EDGE_MODE(EDGE_MODE)
        ) u_edge (
            .clk  (clk),
            .reset(reset),
            .pad  (gpio[i]),
            .dir  (r_dir[i]),
            .clr  (w_clr[i]),
            .sync (w_pin[i]),
            .flag (w_flag[i])
        );
    end

    always_comb begin
        w_rdata = '0;
        case (port_reg_e'(address))
            PORT_REG_OUT:  w_rdata = r_out;
            PORT_REG_DIR:  w_rdata = r_dir;
            PORT_REG_PIN:  w_rdata = w_pin;
            PORT_REG_FLAG: w_rdata = w_flag;
            default:       w_rdata = '0;
        endcase
    end

    // Built only from flag flops, so it cannot glitch on bus activity.
    assign irq = |w_flag;

    tri_state_buffer #(
        .WIDTH(DATA_WIDTH)
    ) u_bus_buf (
        .i_data(w_rdata),
        .i_en  ({DATA_WIDTH{w_rd}}),
        .o_pad (data)
    );

    tri_state_buffer #(
        .WIDTH(DATA_WIDTH)
    ) u_pad_buf (
        .i_data(r_out),
        .i_en  (r_dir),
        .o_pad (gpio)
    );

endmodule : gpio_port
`default_nettype wire
